// File: rtl/alarm_clock_multi.sv
// Alarm clock with N independent alarms, a shared ring/snooze state machine
// and a single view selector used for both display and button editing.
// Time and alarm values are held in binary; the display digits are a purely
// combinational BCD conversion of whichever value is currently in view.
module alarm_clock_multi #(
  parameter int CLK_HZ     = 100000000,
  parameter int N_ALARMS   = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 1
) (
  input  logic                                             ck,
  input  logic                                             reset,
  input  logic                                             mode_p,
  input  logic                                             hh_p,
  input  logic                                             mm_p,
  input  logic                                             en_p,
  input  logic                                             snooze_p,
  input  logic                                             stop_p,
  output logic [$clog2(N_ALARMS+1)-1:0]                    sel,
  output logic [15:0]                                      digits,
  output logic                                             sec_blink,
  output logic [N_ALARMS-1:0]                              alarm_en,
  output logic                                             ringing,
  output logic [((N_ALARMS > 1) ? $clog2(N_ALARMS) : 1)-1:0] ring_idx
);

  localparam int SW = $clog2(N_ALARMS + 1);
  localparam int IW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] SEL_LAST    = SW'(N_ALARMS);
  localparam logic [5:0]    RING_LOAD   = 6'(RING_MIN);
  localparam logic [5:0]    SNOOZE_LOAD = 6'(SNOOZE_MIN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } ring_st_e;

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------
  function automatic logic [5:0] inc60(input logic [5:0] v);
    if (v >= 6'd59) begin
      inc60 = 6'd0;
    end else begin
      inc60 = v + 6'd1;
    end
  endfunction

  function automatic logic [4:0] inc24(input logic [4:0] v);
    if (v >= 5'd23) begin
      inc24 = 5'd0;
    end else begin
      inc24 = v + 5'd1;
    end
  endfunction

  // Two-digit BCD of a 0..59 binary value.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    if (v >= 6'd50) begin
      tens = 4'd5; rem = v - 6'd50;
    end else if (v >= 6'd40) begin
      tens = 4'd4; rem = v - 6'd40;
    end else if (v >= 6'd30) begin
      tens = 4'd3; rem = v - 6'd30;
    end else if (v >= 6'd20) begin
      tens = 4'd2; rem = v - 6'd20;
    end else if (v >= 6'd10) begin
      tens = 4'd1; rem = v - 6'd10;
    end else begin
      tens = 4'd0; rem = v;
    end
    to_bcd = {tens, rem[3:0]};
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hr_q, hr_d;
  logic [4:0]    al_hr_q  [N_ALARMS];
  logic [4:0]    al_hr_d  [N_ALARMS];
  logic [5:0]    al_min_q [N_ALARMS];
  logic [5:0]    al_min_d [N_ALARMS];
  logic [N_ALARMS-1:0] en_q, en_d;
  logic [SW-1:0] sel_q, sel_d;
  ring_st_e      st_q, st_d;
  logic [IW-1:0] ridx_q, ridx_d;
  logic [5:0]    tmr_q, tmr_d;

  logic          sec_tick;
  logic          view_clk;
  logic [IW-1:0] view_idx;
  logic          clk_edit;
  logic          min_roll;
  logic          match_any;
  logic [IW-1:0] match_idx;
  logic [4:0]    view_hr;
  logic [5:0]    view_min;

  // Prescaler: one sec_tick per CLK_HZ cycles, on the last count.
  always_comb begin
    sec_tick = (presc_q == PRESC_LAST);
    if (sec_tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // View decode: sel 0 shows the clock, sel k shows alarm k-1.
  always_comb begin
    view_clk = (sel_q == '0);
    view_idx = IW'(sel_q - SW'(1));
  end

  // Clock time next-state; button edits override the tick carry chain.
  always_comb begin
    clk_edit = view_clk && (hh_p || mm_p);
    // A natural minute rollover only; any clock edit that cycle suppresses it.
    min_roll = sec_tick && (sec_q == 6'd59) && !clk_edit;

    if (view_clk && mm_p) begin
      sec_d = 6'd0;
    end else if (sec_tick) begin
      sec_d = inc60(sec_q);
    end else begin
      sec_d = sec_q;
    end

    if (view_clk && mm_p) begin
      min_d = inc60(min_q);
    end else if (min_roll) begin
      min_d = inc60(min_q);
    end else begin
      min_d = min_q;
    end

    if (view_clk && hh_p) begin
      hr_d = inc24(hr_q);
    end else if (min_roll && (min_q == 6'd59)) begin
      hr_d = inc24(hr_q);
    end else begin
      hr_d = hr_q;
    end
  end

  // Alarm edits, enable toggles and view selection.
  always_comb begin
    al_hr_d  = al_hr_q;
    al_min_d = al_min_q;
    en_d     = en_q;
    if (!view_clk) begin
      if (hh_p) begin
        al_hr_d[view_idx] = inc24(al_hr_q[view_idx]);
      end else begin
        al_hr_d[view_idx] = al_hr_q[view_idx];
      end
      if (mm_p) begin
        al_min_d[view_idx] = inc60(al_min_q[view_idx]);
      end else begin
        al_min_d[view_idx] = al_min_q[view_idx];
      end
      if (en_p) begin
        en_d[view_idx] = ~en_q[view_idx];
      end else begin
        en_d[view_idx] = en_q[view_idx];
      end
    end else begin
      en_d = en_q;
    end

    if (mode_p) begin
      if (sel_q >= SEL_LAST) begin
        sel_d = '0;
      end else begin
        sel_d = sel_q + SW'(1);
      end
    end else begin
      sel_d = sel_q;
    end
  end

  // Alarm match against the post-rollover HH:MM; lowest index wins.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (min_roll && en_q[i] && (al_hr_q[i] == hr_d) && (al_min_q[i] == min_d)) begin
        match_any = 1'b1;
        match_idx = IW'(i);
      end else begin
        match_any = match_any;
      end
    end
  end

  // Ring FSM next-state: IDLE -> RING -> SNOOZE with a minute countdown.
  always_comb begin
    st_d   = st_q;
    ridx_d = ridx_q;
    tmr_d  = tmr_q;
    case (st_q)
      ST_IDLE: begin
        if (match_any) begin
          st_d   = ST_RING;
          ridx_d = match_idx;
          tmr_d  = RING_LOAD;
        end else begin
          st_d = ST_IDLE;
        end
      end
      ST_RING: begin
        if (!en_d[ridx_q] || stop_p) begin
          st_d = ST_IDLE;
        end else if (snooze_p) begin
          st_d  = ST_SNOOZE;
          tmr_d = SNOOZE_LOAD;
        end else if (min_roll) begin
          if (tmr_q <= 6'd1) begin
            st_d  = ST_IDLE;
            tmr_d = 6'd0;
          end else begin
            tmr_d = tmr_q - 6'd1;
          end
        end else begin
          st_d = ST_RING;
        end
      end
      ST_SNOOZE: begin
        if (!en_d[ridx_q] || stop_p) begin
          st_d = ST_IDLE;
        end else if (min_roll) begin
          if (tmr_q <= 6'd1) begin
            st_d  = ST_RING;
            tmr_d = RING_LOAD;
          end else begin
            tmr_d = tmr_q - 6'd1;
          end
        end else begin
          st_d = ST_SNOOZE;
        end
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  // All state registers share one asynchronous active-low reset.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hr_q    <= 5'd0;
      for (int i = 0; i < N_ALARMS; i++) begin
        al_hr_q[i]  <= 5'd0;
        al_min_q[i] <= 6'd0;
      end
      en_q    <= '0;
      sel_q   <= '0;
      st_q    <= ST_IDLE;
      ridx_q  <= '0;
      tmr_q   <= 6'd0;
    end else begin
      presc_q  <= presc_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
      hr_q     <= hr_d;
      al_hr_q  <= al_hr_d;
      al_min_q <= al_min_d;
      en_q     <= en_d;
      sel_q    <= sel_d;
      st_q     <= st_d;
      ridx_q   <= ridx_d;
      tmr_q    <= tmr_d;
    end
  end

  // Display: BCD of the viewed value, combinational from registered state.
  always_comb begin
    if (view_clk) begin
      view_hr  = hr_q;
      view_min = min_q;
    end else begin
      view_hr  = al_hr_q[view_idx];
      view_min = al_min_q[view_idx];
    end
    digits = {to_bcd({1'b0, view_hr}), to_bcd(view_min)};
  end

  assign sel       = sel_q;
  assign sec_blink = sec_q[0];
  assign alarm_en  = en_q;
  assign ringing   = (st_q == ST_RING);
  assign ring_idx  = ridx_q;

endmodule
